// File: rtl/ctrl_pipe_regs_pkg.sv
// rtl/ctrl_pipe_regs_pkg.sv - shared encodings and stage bundle layouts for the control pipeline
package ctrl_pipe_regs_pkg;

  typedef enum logic [1:0] {
    GPRSEL_RD  = 2'b00,
    GPRSEL_RT  = 2'b01,
    GPRSEL_RA  = 2'b10,
    GPRSEL_RSV = 2'b11
  } gprsel_e;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       jal;
    logic [4:0] aluc;
    logic [4:0] rn;
  } idex_t;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [4:0] rn;
  } exmem_t;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } memwb_t;

  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  // A bubble is an all-zero bundle: no valid, no register or memory write.
  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline control register with load/bubble select
module ctrl_stage_reg #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= BUBBLE;
    end
  end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// rtl/ctrl_pipe_regs.sv - ID/EX, EX/MEM, MEM/WB control registers with dest resolve and counters
module ctrl_pipe_regs
  import ctrl_pipe_regs_pkg::*;
#(
  parameter int         CNT_W  = 32,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic             nostall,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wmem,
  input  logic             id_aluimm,
  input  logic             id_jal,
  input  logic [4:0]       id_aluc,
  input  logic [1:0]       id_gprsel,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             cnt_clr,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic             ealuimm,
  output logic             ejal,
  output logic [4:0]       ealuc,
  output logic [4:0]       ern,
  output logic             mwreg,
  output logic             mm2reg,
  output logic             mwmem,
  output logic [4:0]       mrn,
  output logic             wwreg,
  output logic             wm2reg,
  output logic [4:0]       wrn,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  logic       capture;
  logic       stall_ev;
  logic [4:0] rn_sel;
  logic       rn_ok;
  idex_t      idex_d;
  idex_t      idex_q;
  exmem_t     exmem_d;
  exmem_t     exmem_q;
  memwb_t     memwb_d;
  memwb_t     memwb_q;

  assign capture  = id_valid & nostall;
  assign stall_ev = id_valid & ~nostall;

  always_comb begin
    rn_sel = 5'd0;
    rn_ok  = 1'b1;
    case (gprsel_e'(id_gprsel))
      GPRSEL_RD: rn_sel = id_rd;
      GPRSEL_RT: rn_sel = id_rt;
      GPRSEL_RA: rn_sel = RA_REG;
      default:   rn_ok  = 1'b0;
    endcase
  end

  // r0 is never a write target, so it can never become a forwarding source.
  always_comb begin
    idex_d        = IDEX_BUBBLE;
    idex_d.valid  = 1'b1;
    idex_d.wreg   = id_wreg & rn_ok & (rn_sel != 5'd0);
    idex_d.m2reg  = id_m2reg;
    idex_d.wmem   = id_wmem;
    idex_d.aluimm = id_aluimm;
    idex_d.jal    = id_jal;
    idex_d.aluc   = id_aluc;
    idex_d.rn     = rn_sel;
  end

  always_comb begin
    exmem_d       = EXMEM_BUBBLE;
    exmem_d.valid = idex_q.valid;
    exmem_d.wreg  = idex_q.wreg;
    exmem_d.m2reg = idex_q.m2reg;
    exmem_d.wmem  = idex_q.wmem;
    exmem_d.rn    = idex_q.rn;
  end

  always_comb begin
    memwb_d       = MEMWB_BUBBLE;
    memwb_d.valid = exmem_q.valid;
    memwb_d.wreg  = exmem_q.wreg;
    memwb_d.m2reg = exmem_q.m2reg;
    memwb_d.rn    = exmem_q.rn;
  end

  ctrl_stage_reg #(.W(IDEX_W), .BUBBLE(IDEX_BUBBLE)) u_idex (
    .clk  (clk),
    .rstn (rstn),
    .load (capture),
    .d    (idex_d),
    .q    (idex_q)
  );

  // EX/MEM and MEM/WB have no backpressure and advance every cycle.
  ctrl_stage_reg #(.W(EXMEM_W), .BUBBLE(EXMEM_BUBBLE)) u_exmem (
    .clk  (clk),
    .rstn (rstn),
    .load (1'b1),
    .d    (exmem_d),
    .q    (exmem_q)
  );

  ctrl_stage_reg #(.W(MEMWB_W), .BUBBLE(MEMWB_BUBBLE)) u_memwb (
    .clk  (clk),
    .rstn (rstn),
    .load (1'b1),
    .d    (memwb_d),
    .q    (memwb_q)
  );

  assign ewreg   = idex_q.wreg;
  assign em2reg  = idex_q.m2reg;
  assign ewmem   = idex_q.wmem;
  assign ealuimm = idex_q.aluimm;
  assign ejal    = idex_q.jal;
  assign ealuc   = idex_q.aluc;
  assign ern     = idex_q.rn;
  assign mwreg   = exmem_q.wreg;
  assign mm2reg  = exmem_q.m2reg;
  assign mwmem   = exmem_q.wmem;
  assign mrn     = exmem_q.rn;
  assign wwreg   = memwb_q.wreg;
  assign wm2reg  = memwb_q.m2reg;
  assign wrn     = memwb_q.rn;

  // Saturating counters; a clear in the same cycle beats any increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (memwb_q.valid && (retire_cnt != '1)) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// tb/tb_ctrl_pipe_regs.sv - scoreboard bench for ctrl_pipe_regs with a spec-level reference model
module tb_ctrl_pipe_regs;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          id_valid, nostall, id_wreg, id_m2reg, id_wmem, id_aluimm, id_jal;
  logic [4:0]    id_aluc, id_rt, id_rd;
  logic [1:0]    id_gprsel;
  logic          cnt_clr;
  logic          ewreg, em2reg, ewmem, ealuimm, ejal;
  logic [4:0]    ealuc, ern;
  logic          mwreg, mm2reg, mwmem;
  logic [4:0]    mrn;
  logic          wwreg, wm2reg;
  logic [4:0]    wrn;
  logic [CW-1:0] stall_cnt, retire_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_regs #(.CNT_W(CW), .RA_REG(5'd31)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .nostall(nostall),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluimm(id_aluimm), .id_jal(id_jal), .id_aluc(id_aluc),
    .id_gprsel(id_gprsel), .id_rt(id_rt), .id_rd(id_rd), .cnt_clr(cnt_clr),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
    .ejal(ejal), .ealuc(ealuc), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mrn(mrn),
    .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  typedef struct {
    int       due;
    bit       valid, wreg, m2reg, wmem, aluimm, jal;
    bit [4:0] aluc, rn;
  } rec_t;

  typedef struct {
    int due;
    bit stall, clr;
  } ev_t;

  rec_t q_e[$], q_m[$], q_w[$];
  ev_t  q_ev[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   exp_stall = 0, exp_retire = 0;
  bit   last_w_valid = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // What the ID/EX entry must hold, derived from the instruction alone.
  function automatic rec_t model(input bit v, ns, wr, m2, wm, ai, jl,
                                 input bit [4:0] ac, input bit [1:0] gs,
                                 input bit [4:0] rt, rd);
    rec_t r = '{default: 0};
    if (v && ns) begin
      r.valid  = 1;
      r.rn     = (gs == 2'd0) ? rd : (gs == 2'd1) ? rt : (gs == 2'd2) ? 5'd31 : 5'd0;
      r.wreg   = wr && (gs != 2'd3) && (r.rn != 5'd0);
      r.m2reg  = m2;
      r.wmem   = wm;
      r.aluimm = ai;
      r.jal    = jl;
      r.aluc   = ac;
    end
    return r;
  endfunction

  task automatic set_idle();
    id_valid = 0; nostall = 1; id_wreg = 0; id_m2reg = 0; id_wmem = 0;
    id_aluimm = 0; id_jal = 0; id_aluc = 0; id_gprsel = 0; id_rt = 0; id_rd = 0;
    cnt_clr = 0;
  endtask

  task automatic drive(input bit v, ns, wr, m2, wm, ai, jl, input bit [4:0] ac,
                       input bit [1:0] gs, input bit [4:0] rt, rd, input bit clr);
    rec_t r;
    ev_t  e;
    @(posedge clk);
    #1;
    id_valid = v; nostall = ns; id_wreg = wr; id_m2reg = m2; id_wmem = wm;
    id_aluimm = ai; id_jal = jl; id_aluc = ac; id_gprsel = gs; id_rt = rt; id_rd = rd;
    cnt_clr = clr;
    r = model(v, ns, wr, m2, wm, ai, jl, ac, gs, rt, rd);
    r.due = cyc + 1; q_e.push_back(r);
    r.due = cyc + 2; q_m.push_back(r);
    r.due = cyc + 3; q_w.push_back(r);
    e.due = cyc + 1; e.stall = v && !ns; e.clr = clr;
    q_ev.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 5'd0, 2'd0, 5'd0, 5'd0, 0);
  endtask

  // Drops reset right now (mid-cycle) and expects every output to clear immediately.
  task automatic do_reset();
    rstn = 0;
    set_idle();
    #1;
    chk("async_rst_mwmem", {31'd0, mwmem}, 32'd0);
    chk("async_rst_pipe", {2'd0, ewreg, em2reg, ewmem, ealuimm, ejal, ealuc, ern,
                           mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn}, 32'd0);
    chk("async_rst_cnt", {24'd0, stall_cnt, retire_cnt}, 32'd0);
    q_e.delete(); q_m.delete(); q_w.delete(); q_ev.delete();
    exp_stall = 0; exp_retire = 0; last_w_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  always @(negedge clk) begin
    rec_t re, rm, rw;
    ev_t  ev;
    if (rstn && mon_en) begin
      ev = '{default: 0};
      if (q_ev.size() > 0 && q_ev[0].due == cyc) ev = q_ev.pop_front();
      if (ev.clr) begin
        exp_stall  = 0;
        exp_retire = 0;
      end else begin
        if (ev.stall && exp_stall < CMAX) exp_stall++;
        if (last_w_valid && exp_retire < CMAX) exp_retire++;
      end
      re = '{default: 0};
      rm = '{default: 0};
      rw = '{default: 0};
      if (q_e.size() > 0 && q_e[0].due == cyc) re = q_e.pop_front();
      if (q_m.size() > 0 && q_m[0].due == cyc) rm = q_m.pop_front();
      if (q_w.size() > 0 && q_w[0].due == cyc) rw = q_w.pop_front();
      last_w_valid = rw.valid;

      chk("e_ctrl", {27'd0, ewreg, em2reg, ewmem, ealuimm, ejal},
          {27'd0, re.wreg, re.m2reg, re.wmem, re.aluimm, re.jal});
      chk("ealuc", {27'd0, ealuc}, {27'd0, re.aluc});
      chk("ern", {27'd0, ern}, {27'd0, re.rn});
      chk("m_ctrl", {29'd0, mwreg, mm2reg, mwmem}, {29'd0, rm.wreg, rm.m2reg, rm.wmem});
      chk("mrn", {27'd0, mrn}, {27'd0, rm.rn});
      chk("w_ctrl", {30'd0, wwreg, wm2reg}, {30'd0, rw.wreg, rw.m2reg});
      chk("wrn", {27'd0, wrn}, {27'd0, rw.rn});
      chk("stall_cnt", {28'd0, stall_cnt}, exp_stall);
      chk("retire_cnt", {28'd0, retire_cnt}, exp_retire);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pipe", {2'd0, ewreg, em2reg, ewmem, ealuimm, ejal, ealuc, ern,
                     mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn}, 32'd0);
    chk("rst_cnt", {24'd0, stall_cnt, retire_cnt}, 32'd0);
    rstn = 1;
    mon_en = 1;
    idle(6);

    // addu rd=5
    drive(1, 1, 1, 0, 0, 0, 0, 5'h01, 2'd0, 5'd3, 5'd5, 0);
    idle(5);

    // lw rt=8, then a dependent op stalled for one cycle
    drive(1, 1, 1, 1, 0, 1, 0, 5'h02, 2'd1, 5'd8, 5'd0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 5'h01, 2'd0, 5'd8, 5'd9, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 5'h01, 2'd0, 5'd8, 5'd9, 0);
    idle(5);

    // jal, write to r0, reserved gprsel
    drive(1, 1, 1, 0, 0, 0, 1, 5'h03, 2'd2, 5'd1, 5'd2, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 5'h01, 2'd0, 5'd4, 5'd0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 5'h01, 2'd3, 5'd6, 5'd7, 0);
    idle(5);

    // sw, then reset while it sits in EX/MEM
    drive(1, 1, 0, 0, 1, 1, 0, 5'h02, 2'd1, 5'd4, 5'd0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 5'd0, 2'd0, 5'd0, 5'd0, 0);
    @(posedge clk);
    #1;
    chk("sw_mwmem_pre", {31'd0, mwmem}, 32'd1);
    #1;
    do_reset();
    idle(6);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
            $urandom_range(0, 39) == 0);
    end

    // Continuous stall to saturate, then clear while still stalling
    for (int i = 0; i < 20; i++) drive(1, 0, 1, 0, 0, 0, 0, 5'h01, 2'd0, 5'd1, 5'd2, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 5'h01, 2'd0, 5'd1, 5'd2, 1);
    idle(6);

    repeat (4) @(negedge clk);
    #1;
    chk("queues_drained", q_e.size() + q_m.size() + q_w.size() + q_ev.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
